// File: rtl/dma_seq_pkg.sv
// Shared types for the DMA descriptor sequencer: descriptor record,
// sequencer states and sticky error bit positions.
package dma_seq_pkg;

  localparam int DESC_ADDR_W = 42;
  localparam int DESC_LEN_W  = 32;

  typedef struct packed {
    logic [DESC_ADDR_W-1:0] src;
    logic [DESC_ADDR_W-1:0] dst;
    logic [DESC_LEN_W-1:0]  len_lines;
  } t_dma_desc;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } t_seq_state;

  localparam int ERR_OVF  = 0;
  localparam int ERR_ZLEN = 1;
  localparam int ERR_SPUR = 2;

endpackage

// File: rtl/dma_desc_fifo.sv
// Synchronous descriptor FIFO; the head entry is read straight from the
// storage registers so it is valid whenever the FIFO is non-empty.
module dma_desc_fifo
  import dma_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  t_dma_desc              wdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output t_dma_desc              head
);

  localparam int PW = $clog2(DEPTH);

  t_dma_desc       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (level == (PW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage holds data only; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dma_desc_queue.sv
// Descriptor sequencer feeding the DMA engine: queues host copy requests,
// issues them one at a time, counts completions and flags sticky errors.
module dma_desc_queue
  import dma_seq_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 42,
  parameter int LEN_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   desc_push,
  input  logic [ADDR_W-1:0]      desc_src,
  input  logic [ADDR_W-1:0]      desc_dst,
  input  logic [63:0]            desc_bytes,
  input  logic                   abort,
  input  logic                   err_clr,
  output logic                   desc_full,
  output logic [$clog2(DEPTH):0] desc_level,
  output logic                   dma_start,
  output logic [ADDR_W-1:0]      dma_rd_addr,
  output logic [ADDR_W-1:0]      dma_wr_addr,
  output logic [LEN_W-1:0]       dma_len,
  input  logic                   dma_done,
  output logic                   busy,
  output logic [31:0]            done_count,
  output logic [2:0]             err
);

  // Round a byte count up to whole 64-byte lines; the extra sum bit keeps
  // lengths near 2^64 from wrapping before the shift.
  function automatic logic [LEN_W-1:0] bytes_to_lines(input logic [63:0] bytes);
    logic [64:0] sum;
    sum = {1'b0, bytes} + 65'd63;
    return LEN_W'(sum >> 6);
  endfunction

  t_seq_state      state;
  t_dma_desc       wdesc;
  t_dma_desc       head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            zero_len;
  logic            push_ok;
  logic            pop_req;
  logic [2:0]      err_ev;

  assign zero_len = (desc_bytes == '0);
  assign push_ok  = desc_push & ~fifo_full & ~zero_len & ~abort;
  // abort also discards the head, so nothing is popped on an abort cycle
  assign pop_req  = (state == IDLE) & ~fifo_empty & ~abort;

  always_comb begin
    wdesc           = '0;
    wdesc.src       = DESC_ADDR_W'(desc_src);
    wdesc.dst       = DESC_ADDR_W'(desc_dst);
    wdesc.len_lines = DESC_LEN_W'(bytes_to_lines(desc_bytes));
  end

  always_comb begin
    err_ev           = '0;
    err_ev[ERR_OVF]  = desc_push & ~abort & fifo_full;
    err_ev[ERR_ZLEN] = desc_push & ~abort & zero_len;
    err_ev[ERR_SPUR] = dma_done & (state != WAIT);
  end

  dma_desc_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .pop   (pop_req),
    .flush (abort),
    .wdata (wdesc),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (desc_level),
    .head  (head)
  );

  assign desc_full = fifo_full;
  assign busy      = (state != IDLE) | ~fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      dma_start   <= 1'b0;
      dma_rd_addr <= '0;
      dma_wr_addr <= '0;
      dma_len     <= '0;
      done_count  <= '0;
      err         <= '0;
    end else begin
      dma_start <= 1'b0;
      // a new event in the clear cycle keeps its bit set
      err <= (err & {3{~err_clr}}) | err_ev;
      case (state)
        IDLE: begin
          if (pop_req) begin
            dma_rd_addr <= head.src[ADDR_W-1:0];
            dma_wr_addr <= head.dst[ADDR_W-1:0];
            dma_len     <= head.len_lines[LEN_W-1:0];
            dma_start   <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (dma_done) begin
            done_count <= done_count + 32'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_desc_queue.sv
// Randomized and directed bench for dma_desc_queue against a queue-based
// reference model of the sequencer.
module tb_dma_desc_queue;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 42;
  localparam int LEN_W  = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              desc_push = 1'b0;
  logic [ADDR_W-1:0] desc_src = '0;
  logic [ADDR_W-1:0] desc_dst = '0;
  logic [63:0]       desc_bytes = '0;
  logic              abort = 1'b0;
  logic              err_clr = 1'b0;
  logic              desc_full;
  logic [3:0]        desc_level;
  logic              dma_start;
  logic [ADDR_W-1:0] dma_rd_addr;
  logic [ADDR_W-1:0] dma_wr_addr;
  logic [LEN_W-1:0]  dma_len;
  logic              dma_done = 1'b0;
  logic              busy;
  logic [31:0]       done_count;
  logic [2:0]        err;

  dma_desc_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .desc_push   (desc_push),
    .desc_src    (desc_src),
    .desc_dst    (desc_dst),
    .desc_bytes  (desc_bytes),
    .abort       (abort),
    .err_clr     (err_clr),
    .desc_full   (desc_full),
    .desc_level  (desc_level),
    .dma_start   (dma_start),
    .dma_rd_addr (dma_rd_addr),
    .dma_wr_addr (dma_wr_addr),
    .dma_len     (dma_len),
    .dma_done    (dma_done),
    .busy        (busy),
    .done_count  (done_count),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
  } mdesc_t;

  // Reference model: pending copies, whether a copy is outstanding, and
  // whether this is the single start cycle of that copy.
  mdesc_t            m_q[$];
  bit                m_inflight;
  bit                m_start;
  logic [ADDR_W-1:0] m_rd;
  logic [ADDR_W-1:0] m_wr;
  logic [LEN_W-1:0]  m_len;
  logic [31:0]       m_done;
  logic [2:0]        m_err;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [LEN_W-1:0] m_lines(input logic [63:0] b);
    logic [63:0] n;
    n = b / 64 + (((b % 64) != 0) ? 64'd1 : 64'd0);
    return n[LEN_W-1:0];
  endfunction

  task automatic model_step();
    bit     waiting, full, accept, pop;
    mdesc_t d;
    if (reset) begin
      m_q.delete();
      m_inflight = 0;
      m_start    = 0;
      m_rd       = '0;
      m_wr       = '0;
      m_len      = '0;
      m_done     = '0;
      m_err      = '0;
    end else begin
      waiting = m_inflight && !m_start;
      full    = (m_q.size() == DEPTH);
      accept  = desc_push && !full && (desc_bytes != 0) && !abort;
      m_err   = (err_clr ? 3'b000 : m_err)
              | {dma_done && !waiting,
                 desc_push && !abort && (desc_bytes == 0),
                 desc_push && !abort && full};
      pop     = !m_inflight && (m_q.size() > 0) && !abort;
      m_start = pop;
      if (pop) begin
        d = m_q.pop_front();
        m_rd = d.src;
        m_wr = d.dst;
        m_len = d.len;
        m_inflight = 1;
      end else if (waiting && dma_done) begin
        m_done = m_done + 32'd1;
        m_inflight = 0;
      end
      if (abort) m_q.delete();
      if (accept) begin
        d.src = desc_src;
        d.dst = desc_dst;
        d.len = m_lines(desc_bytes);
        m_q.push_back(d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("desc_full",   64'(desc_full),   64'(m_q.size() == DEPTH));
      chk("desc_level",  64'(desc_level),  64'(m_q.size()));
      chk("dma_start",   64'(dma_start),   64'(m_start));
      chk("dma_rd_addr", 64'(dma_rd_addr), 64'(m_rd));
      chk("dma_wr_addr", 64'(dma_wr_addr), 64'(m_wr));
      chk("dma_len",     64'(dma_len),     64'(m_len));
      chk("busy",        64'(busy),        64'(m_inflight || (m_q.size() > 0)));
      chk("done_count",  64'(done_count),  64'(m_done));
      chk("err",         64'(err),         64'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
    desc_push = 1'b0;
    abort     = 1'b0;
    err_clr   = 1'b0;
    dma_done  = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic push_desc(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                           input logic [63:0] b);
    desc_push  = 1'b1;
    desc_src   = s;
    desc_dst   = d;
    desc_bytes = b;
    tick();
  endtask

  task automatic finish_one();
    int k = 0;
    while (!(m_inflight && !m_start) && k < 50) begin
      tick();
      k++;
    end
    chk("wait_state_timeout", 64'(k < 50), 64'd1);
    dma_done = 1'b1;
    tick();
  endtask

  initial begin
    logic [63:0] r64;
    int          r;

    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    chk("reset_level", 64'(desc_level), 64'd0);
    chk("reset_err",   64'(err),        64'd0);

    // single copy
    push_desc(42'h100, 42'h200, 64'd4096);
    tick();
    chk("single_start", 64'(dma_start),   64'd1);
    chk("single_len",   64'(dma_len),     64'd64);
    chk("single_src",   64'(dma_rd_addr), 64'h100);
    chk("single_dst",   64'(dma_wr_addr), 64'h200);
    tick();
    chk("single_start_pulse", 64'(dma_start), 64'd0);
    finish_one();
    chk("single_done", 64'(done_count), 64'd1);
    chk("single_busy", 64'(busy),       64'd0);

    // rounding
    push_desc(42'h1, 42'h2, 64'd1);
    tick();
    chk("round_1", 64'(dma_len), 64'd1);
    finish_one();
    push_desc(42'h3, 42'h4, 64'd65);
    tick();
    chk("round_65", 64'(dma_len), 64'd2);
    finish_one();
    push_desc(42'h5, 42'h6, 64'd0);
    chk("zlen_err",   64'(err),        64'd2);
    chk("zlen_level", 64'(desc_level), 64'd0);
    err_clr = 1'b1;
    tick();
    chk("zlen_clr", 64'(err), 64'd0);

    // overflow with the DMA stalled
    push_desc(42'h10, 42'h20, 64'd640);
    tick();
    for (int i = 0; i < 9; i++) push_desc(42'(i + 'h1000), 42'(i + 'h2000), 64'd128);
    chk("ovf_level", 64'(desc_level), 64'd8);
    chk("ovf_full",  64'(desc_full),  64'd1);
    chk("ovf_err",   64'(err),        64'd1);
    for (int i = 0; i < 9; i++) finish_one();
    repeat (3) tick();
    chk("ovf_done",  64'(done_count), 64'd12);
    chk("ovf_busy",  64'(busy),       64'd0);
    chk("ovf_start", 64'(dma_start),  64'd0);
    err_clr = 1'b1;
    tick();

    // abort with one copy in flight
    push_desc(42'h30, 42'h40, 64'd256);
    tick();
    for (int i = 0; i < 5; i++) push_desc(42'(i + 'h3000), 42'(i + 'h4000), 64'd64);
    chk("abort_level_pre", 64'(desc_level), 64'd5);
    abort = 1'b1;
    tick();
    chk("abort_level", 64'(desc_level), 64'd0);
    finish_one();
    repeat (5) tick();
    chk("abort_done", 64'(done_count), 64'd13);
    chk("abort_busy", 64'(busy),       64'd0);

    // spurious completion and clear priority
    dma_done = 1'b1;
    tick();
    chk("spur_err",  64'(err),        64'd4);
    chk("spur_done", 64'(done_count), 64'd13);
    err_clr = 1'b1;
    dma_done = 1'b1;
    tick();
    chk("spur_clr_race", 64'(err), 64'd4);
    err_clr = 1'b1;
    tick();
    chk("spur_clr", 64'(err), 64'd0);

    // reset while waiting with a backlog
    push_desc(42'h50, 42'h60, 64'd512);
    tick();
    tick();
    for (int i = 0; i < 3; i++) push_desc(42'(i + 'h5000), 42'(i + 'h6000), 64'd64);
    chk("rst_level_pre", 64'(desc_level), 64'd3);
    reset = 1'b1;
    tick();
    chk("rst_level", 64'(desc_level),  64'd0);
    chk("rst_done",  64'(done_count),  64'd0);
    chk("rst_busy",  64'(busy),        64'd0);
    chk("rst_src",   64'(dma_rd_addr), 64'd0);
    chk("rst_len",   64'(dma_len),     64'd0);
    chk("rst_start", 64'(dma_start),   64'd0);
    repeat (4) tick();
    chk("rst_no_issue", 64'(done_count + 32'(dma_start) + 32'(desc_level)), 64'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40) begin
        desc_push = 1'b1;
        r64 = {$urandom(), $urandom()};
        desc_src = r64[ADDR_W-1:0];
        r64 = {$urandom(), $urandom()};
        desc_dst = r64[ADDR_W-1:0];
        case ($urandom_range(0, 4))
          0: desc_bytes = 64'($urandom_range(0, 200));
          1: desc_bytes = {$urandom(), $urandom()};
          2: desc_bytes = 64'($urandom_range(0, 64)) << 6;
          3: desc_bytes = 64'hFFFF_FFFF_FFFF_FFC0 + 64'($urandom_range(0, 63));
          default: desc_bytes = 64'd0;
        endcase
      end
      abort   = ($urandom_range(0, 31) == 0);
      err_clr = ($urandom_range(0, 15) == 0);
      if (m_inflight && !m_start) dma_done = ($urandom_range(0, 2) == 0);
      else                        dma_done = ($urandom_range(0, 63) == 0);
      reset   = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
